// File: rtl/divider_io_pkg.sv
// Shared types and constants for the array divider I/O wrapper: FSM states,
// the result record stored in the FIFO, and the saturation values.
package divider_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WAIT_FIFO
    } state_t;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
    } result_t;

    localparam logic [7:0] Q_SAT = 8'hFF;
    localparam logic [7:0] R_OVF = 8'h00;

    // A quotient overflows 8 bits exactly when the dividend's upper byte
    // is not smaller than the divisor; only trust the array otherwise.
    function automatic result_t make_result(
        input logic [15:0] n,
        input logic [7:0]  d,
        input logic [7:0]  q_arr,
        input logic [7:0]  r_arr
    );
        result_t res;
        res.dz  = (d == 8'd0);
        res.ovf = !res.dz && (n[15:8] >= d);
        if (res.dz) begin
            res.q = Q_SAT;
            res.r = n[7:0];
        end else if (res.ovf) begin
            res.q = Q_SAT;
            res.r = R_OVF;
        end else begin
            res.q = q_arr;
            res.r = r_arr;
        end
        return res;
    endfunction

endpackage

// File: rtl/divider_result_fifo.sv
// Small result FIFO with a show-ahead head; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module divider_result_fifo
    import divider_io_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  result_t push_data,
    input  logic    pop,
    output result_t head,
    output logic    full,
    output logic    empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    result_t       mem [DEPTH];
    logic          pop_ok;
    logic          push_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head is forced to zero when empty so outputs read 0 during reset.
    assign head = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/divider_array_io_stage.sv
// Operand/result wrapper around the external 16/8 array divider: registers
// operands, waits a settle time, then queues the flagged result.
module divider_array_io_stage
    import divider_io_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int FIFO_DEPTH    = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_n,
    input  logic [7:0]           in_d,
    output logic [15:0]          div_n_o,
    output logic [7:0]           div_d_o,
    input  logic [7:0]           div_q_i,
    input  logic [7:0]           div_r_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_q,
    output logic [7:0]           out_r,
    output logic                 out_dz,
    output logic                 out_ovf,
    output logic [ERR_CNT_W-1:0] err_count
);
    state_t                state_reg;
    logic                  in_ready_reg;
    logic [3:0]            cnt_reg;
    logic [15:0]           opn_reg;
    logic [7:0]            opd_reg;
    logic [ERR_CNT_W-1:0]  err_count_reg;

    result_t               cur_result;
    result_t               head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  space;
    logic                  push;

    assign cur_result = make_result(opn_reg, opd_reg, div_q_i, div_r_i);
    assign pop        = !fifo_empty && out_ready;
    assign space      = !fifo_full || pop;

    always_comb begin
        push = 1'b0;
        if (((state_reg == SETTLE) && (cnt_reg == 4'd0)) || (state_reg == WAIT_FIFO)) begin
            push = space;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            cnt_reg       <= '0;
            opn_reg       <= '0;
            opd_reg       <= '0;
            err_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_ready_reg && in_valid) begin
                        opn_reg      <= in_n;
                        opd_reg      <= in_d;
                        cnt_reg      <= 4'(SETTLE_CYCLES - 1);
                        state_reg    <= SETTLE;
                        in_ready_reg <= 1'b0;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else if (space) begin
                        state_reg    <= IDLE;
                        in_ready_reg <= 1'b1;
                    end else begin
                        state_reg <= WAIT_FIFO;
                    end
                end
                WAIT_FIFO: begin
                    if (space) begin
                        state_reg    <= IDLE;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b0;
                end
            endcase
            if (push && (cur_result.dz || cur_result.ovf) && (err_count_reg != '1)) begin
                err_count_reg <= err_count_reg + 1'b1;
            end
        end
    end

    divider_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(cur_result),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign in_ready  = in_ready_reg;
    assign div_n_o   = opn_reg;
    assign div_d_o   = opd_reg;
    assign out_valid = !fifo_empty;
    assign out_q     = head.q;
    assign out_r     = head.r;
    assign out_dz    = head.dz;
    assign out_ovf   = head.ovf;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_divider_array_io_stage.sv
// Directed plus randomized checks of the divider I/O stage against an
// arithmetic reference model; two instances cover settle times 1 and 4.
module tb_divider_array_io_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, out_dz1, out_ovf1;
    logic [15:0] in_n1, div_n1;
    logic [7:0]  in_d1, div_d1, div_q1, div_r1, out_q1, out_r1, err1;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, out_dz4, out_ovf4;
    logic [15:0] in_n4, div_n4;
    logic [7:0]  in_d4, div_d4, div_q4, div_r4, out_q4, out_r4, err4;

    divider_array_io_stage #(.SETTLE_CYCLES(1), .FIFO_DEPTH(2), .ERR_CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_n(in_n1), .in_d(in_d1), .div_n_o(div_n1), .div_d_o(div_d1),
        .div_q_i(div_q1), .div_r_i(div_r1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_q(out_q1), .out_r(out_r1), .out_dz(out_dz1), .out_ovf(out_ovf1), .err_count(err1)
    );

    divider_array_io_stage #(.SETTLE_CYCLES(4), .FIFO_DEPTH(2), .ERR_CNT_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_n(in_n4), .in_d(in_d4), .div_n_o(div_n4), .div_d_o(div_d4),
        .div_q_i(div_q4), .div_r_i(div_r4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_q(out_q4), .out_r(out_r4), .out_dz(out_dz4), .out_ovf(out_ovf4), .err_count(err4)
    );

    // Exact array divider model (low byte of the true quotient/remainder).
    function automatic logic [7:0] arr_q(input logic [15:0] n, input logic [7:0] d);
        if (d == 8'd0) return 8'd0;
        return 8'(n / 16'(d));
    endfunction
    function automatic logic [7:0] arr_r(input logic [15:0] n, input logic [7:0] d);
        if (d == 8'd0) return 8'd0;
        return 8'(n % 16'(d));
    endfunction

    always_comb begin
        div_q1 = arr_q(div_n1, div_d1);
        div_r1 = arr_r(div_n1, div_d1);
        div_q4 = arr_q(div_n4, div_d4);
        div_r4 = arr_r(div_n4, div_d4);
    end

    typedef struct {
        int q;
        int r;
        int dz;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   exp_err;
    int   exp_err4;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t expect_of(input int n, input int d);
        exp_t e;
        if (d == 0) begin
            e.q = 255; e.r = n % 256; e.dz = 1; e.ovf = 0;
        end else if (n / d > 255) begin
            e.q = 255; e.r = 0; e.dz = 0; e.ovf = 1;
        end else begin
            e.q = n / d; e.r = n % d; e.dz = 0; e.ovf = 0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send1(input int n, input int d);
        int t = 0;
        exp_t e;
        while (in_ready1 !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send1_in_ready_timeout", int'(in_ready1), 1);
        in_n1 = 16'(n);
        in_d1 = 8'(d);
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        e = expect_of(n, d);
        exp_q.push_back(e);
        if ((e.dz != 0 || e.ovf != 0) && exp_err < 255) exp_err++;
        $display("send1 n=%04h d=%02h", n, d);
    endtask

    task automatic recv1(input string tag);
        int t = 0;
        exp_t e;
        while (out_valid1 !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk({tag, "_out_valid_timeout"}, int'(out_valid1), 1);
        e = exp_q.pop_front();
        chk({tag, "_q"}, int'(out_q1), e.q);
        chk({tag, "_r"}, int'(out_r1), e.r);
        chk({tag, "_dz"}, int'(out_dz1), e.dz);
        chk({tag, "_ovf"}, int'(out_ovf1), e.ovf);
        $display("recv1 %s q=%02h r=%02h dz=%0d ovf=%0d", tag, out_q1, out_r1, out_dz1, out_ovf1);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
    endtask

    task automatic send4(input int n, input int d);
        int t = 0;
        exp_t e;
        while (in_ready4 !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send4_in_ready_timeout", int'(in_ready4), 1);
        in_n4 = 16'(n);
        in_d4 = 8'(d);
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        e = expect_of(n, d);
        if ((e.dz != 0 || e.ovf != 0) && exp_err4 < 255) exp_err4++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready1), 0);
        chk({tag, "_out_valid"}, int'(out_valid1), 0);
        chk({tag, "_div_n"}, int'(div_n1), 0);
        chk({tag, "_div_d"}, int'(div_d1), 0);
        chk({tag, "_out_q"}, int'(out_q1), 0);
        chk({tag, "_out_r"}, int'(out_r1), 0);
        chk({tag, "_flags"}, int'({out_dz1, out_ovf1}), 0);
        chk({tag, "_err"}, int'(err1), 0);
        $display("reset check %s", tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        in_valid1 = 1'b0; in_n1 = '0; in_d1 = '0; out_ready1 = 1'b0;
        in_valid4 = 1'b0; in_n4 = '0; in_d4 = '0; out_ready4 = 1'b0;
        exp_err = 0;
        exp_err4 = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", int'(in_ready1), 1);

        // 1: basic latency with SETTLE_CYCLES=1
        send1(16'h03E8, 8'h0A);
        chk("t1_div_n", int'(div_n1), 16'h03E8);
        chk("t1_in_ready_low", int'(in_ready1), 0);
        chk("t1_out_valid_early", int'(out_valid1), 0);
        @(negedge clk);
        chk("t1_out_valid", int'(out_valid1), 1);
        recv1("t1");

        // 2: divide by zero
        chk("t2_err_before", int'(err1), 0);
        send1(16'h1234, 8'h00);
        recv1("t2");
        chk("t2_err_after", int'(err1), 1);

        // 3: overflow and its boundary
        send1(16'h0A00, 8'h0A);
        recv1("t3_ovf");
        chk("t3_err", int'(err1), exp_err);
        send1(16'h09FF, 8'h0A);
        recv1("t3_boundary");
        chk("t3_err_boundary", int'(err1), exp_err);

        // 4: backpressure, third result waits for space
        send1(16'h0100, 8'h03);
        send1(16'h0200, 8'h05);
        send1(16'h0300, 8'h07);
        repeat (3) @(negedge clk);
        chk("t4_in_ready_wait", int'(in_ready1), 0);
        chk("t4_out_valid", int'(out_valid1), 1);
        chk("t4_div_n_held", int'(div_n1), 16'h0300);
        chk("t4_head_q", int'(out_q1), exp_q[0].q);
        chk("t4_head_r", int'(out_r1), exp_q[0].r);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        e = exp_q.pop_front();
        chk("t4_in_ready_after_pop", int'(in_ready1), 1);
        recv1("t4_second");
        recv1("t4_third");
        chk("t4_drained", int'(out_valid1), 0);

        // 5a: reset during SETTLE
        send1(16'h4321, 8'h55);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5a_low");
        repeat (2) @(negedge clk);
        check_reset_outputs("t5a_held");
        rst_n = 1'b1;
        exp_q.delete();
        exp_err = 0;
        @(negedge clk);
        chk("t5a_in_ready", int'(in_ready1), 1);
        repeat (3) @(negedge clk);
        chk("t5a_no_stale", int'(out_valid1), 0);

        // 5b: reset with FIFO full and a result waiting
        send1(16'h0010, 8'h00);
        send1(16'h0020, 8'h00);
        send1(16'h0030, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5b_low");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_err = 0;
        @(negedge clk);
        chk("t5b_in_ready", int'(in_ready1), 1);
        repeat (4) @(negedge clk);
        chk("t5b_no_stale", int'(out_valid1), 0);
        chk("t5b_err", int'(err1), 0);

        // Randomized operations with random backpressure
        for (int i = 0; i < 60; i++) begin
            int n;
            int d;
            int kind;
            while (exp_q.size() >= 2) recv1("rand");
            n = int'($urandom_range(0, 65535));
            kind = int'($urandom_range(0, 3));
            if (kind == 0) d = 0;
            else if (kind == 1) d = int'($urandom_range(1, 15));
            else d = int'($urandom_range(0, 255));
            send1(n, d);
            if ($urandom_range(0, 1) == 1) recv1("rand");
        end
        while (exp_q.size() > 0) recv1("rand_drain");
        chk("rand_err", int'(err1), exp_err);

        // 6: SETTLE_CYCLES=4 latency
        send4(16'h03E8, 8'h0A);
        for (int k = 0; k < 4; k++) begin
            chk("t6_in_ready_low", int'(in_ready4), 0);
            chk("t6_out_valid_low", int'(out_valid4), 0);
            @(negedge clk);
        end
        chk("t6_out_valid", int'(out_valid4), 1);
        chk("t6_in_ready", int'(in_ready4), 1);
        chk("t6_q", int'(out_q4), 8'h64);
        chk("t6_r", int'(out_r4), 8'h00);
        $display("t6 latency q=%02h r=%02h", out_q4, out_r4);

        // 6: err_count saturation with a draining consumer
        out_ready4 = 1'b1;
        for (int i = 0; i < 254; i++) send4(int'($urandom_range(0, 65535)), 0);
        repeat (6) @(negedge clk);
        chk("t6_err_254", int'(err4), exp_err4);
        for (int i = 0; i < 46; i++) send4(int'($urandom_range(0, 65535)), 0);
        repeat (6) @(negedge clk);
        chk("t6_err_sat", int'(err4), exp_err4);
        chk("t6_err_sat_ff", int'(err4), 8'hFF);
        $display("t6 saturation err_count=%02h", err4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
